// File: rtl/branch_resolve_pkg.sv
// Shared constants for the branch resolution unit: jump encodings, address
// width, FSM state encodings.
package branch_resolve_pkg;

    localparam int BUS_ADDR_MEM = 64;

    localparam logic JMP_EN    = 1'b1;
    localparam logic JMP_DIS   = 1'b0;
    localparam logic JMP_RIGHT = 1'b0;
    localparam logic JMP_ERROR = 1'b1;

    localparam logic [BUS_ADDR_MEM-1:0] MEM_ADDR_ZERO = '0;

    localparam logic [0:0] BR_IDLE  = 1'b0;
    localparam logic [0:0] BR_FLUSH = 1'b1;

    // Classify a resolved instruction: any pc desync, direction disagreement
    // or taken-taken target disagreement is an error.
    function automatic logic resolve_outcome(input logic pc_mismatch,
                                             input logic actual_taken,
                                             input logic pred_taken,
                                             input logic tgt_mismatch);
        logic wrong;
        wrong = pc_mismatch
              | (actual_taken != pred_taken)
              | (actual_taken & pred_taken & tgt_mismatch);
        return wrong ? JMP_ERROR : JMP_RIGHT;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/EX/redirect/update bus of the branch resolution unit.
// master = pipeline side driving fetch and EX info, slave = resolver.
interface branch_resolve_if #(parameter int ADDR_W = 64);
    logic              if_valid_i;
    logic [ADDR_W-1:0] if_pc_i;
    logic              pred_jmp_i;
    logic [ADDR_W-1:0] pred_target_i;
    logic              ex_valid_i;
    logic              ex_is_jmp_i;
    logic [ADDR_W-1:0] ex_pc_i;
    logic              ex_jmp_en_i;
    logic [ADDR_W-1:0] ex_target_i;
    logic              redirect_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              upd_valid_o;
    logic [ADDR_W-1:0] upd_pc_o;
    logic              upd_jmp_en_o;
    logic [ADDR_W-1:0] upd_target_o;

    modport master (
        output if_valid_i, if_pc_i, pred_jmp_i, pred_target_i,
        output ex_valid_i, ex_is_jmp_i, ex_pc_i, ex_jmp_en_i, ex_target_i,
        input  redirect_o, redirect_pc_o,
        input  upd_valid_o, upd_pc_o, upd_jmp_en_o, upd_target_o
    );

    modport slave (
        input  if_valid_i, if_pc_i, pred_jmp_i, pred_target_i,
        input  ex_valid_i, ex_is_jmp_i, ex_pc_i, ex_jmp_en_i, ex_target_i,
        output redirect_o, redirect_pc_o,
        output upd_valid_o, upd_pc_o, upd_jmp_en_o, upd_target_o
    );
endinterface

// File: rtl/br_shadow_pipe.sv
// DEPTH-deep shift register carrying fetch-time predictions down to EX.
// Stall holds every stage; flush clears all valid bits and wins over stall.
module br_shadow_pipe #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic              in_jmp_i,
    input  logic [ADDR_W-1:0] in_tgt_i,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic              head_jmp_o,
    output logic [ADDR_W-1:0] head_tgt_o
);

    logic              v_q   [DEPTH];
    logic [ADDR_W-1:0] pc_q  [DEPTH];
    logic              jmp_q [DEPTH];
    logic [ADDR_W-1:0] tgt_q [DEPTH];

    logic              src_v   [DEPTH];
    logic [ADDR_W-1:0] src_pc  [DEPTH];
    logic              src_jmp [DEPTH];
    logic [ADDR_W-1:0] src_tgt [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Stage 0 is fed by fetch, every later stage by its predecessor.
            if (gi == 0) begin : g_first
                assign src_v[gi]   = in_valid_i;
                assign src_pc[gi]  = in_pc_i;
                assign src_jmp[gi] = in_jmp_i;
                assign src_tgt[gi] = in_tgt_i;
            end else begin : g_rest
                assign src_v[gi]   = v_q[gi-1];
                assign src_pc[gi]  = pc_q[gi-1];
                assign src_jmp[gi] = jmp_q[gi-1];
                assign src_tgt[gi] = tgt_q[gi-1];
            end

            // Per-stage register: flush kills validity, stall holds, else shift.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[gi]   <= 1'b0;
                    pc_q[gi]  <= '0;
                    jmp_q[gi] <= 1'b0;
                    tgt_q[gi] <= '0;
                end else if (flush_i) begin
                    v_q[gi] <= 1'b0;
                end else if (!stall_i) begin
                    v_q[gi]   <= src_v[gi];
                    pc_q[gi]  <= src_pc[gi];
                    jmp_q[gi] <= src_jmp[gi];
                    tgt_q[gi] <= src_tgt[gi];
                end
            end
        end
    endgenerate

    assign head_valid_o = v_q[DEPTH-1];
    assign head_pc_o    = pc_q[DEPTH-1];
    assign head_jmp_o   = jmp_q[DEPTH-1];
    assign head_tgt_o   = tgt_q[DEPTH-1];

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compares the shadowed fetch prediction
// with the EX outcome, and on a mispredict issues a registered redirect,
// a BTB update and a fixed-length front-end flush.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int ADDR_W       = BUS_ADDR_MEM,
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_resolve_if.slave   bus,
    input  logic              stall_i,
    output logic              flush_o,
    output logic              sync_err_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    logic              head_v;
    logic [ADDR_W-1:0] head_pc;
    logic              head_jmp;
    logic [ADDR_W-1:0] head_tgt;

    logic [0:0] state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;

    logic              redirect_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic              upd_valid_q;
    logic [ADDR_W-1:0] upd_pc_q;
    logic              upd_jmp_en_q;
    logic [ADDR_W-1:0] upd_target_q;
    logic              sync_err_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    logic resolve, actual_taken, pc_mismatch, mispredict;

    assign flush_o = (state_q == BR_FLUSH);

    br_shadow_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_shadow (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_o),
        .in_valid_i   (bus.if_valid_i),
        .in_pc_i      (bus.if_pc_i),
        .in_jmp_i     (bus.pred_jmp_i),
        .in_tgt_i     (bus.pred_target_i),
        .head_valid_o (head_v),
        .head_pc_o    (head_pc),
        .head_jmp_o   (head_jmp),
        .head_tgt_o   (head_tgt)
    );

    // Compare the head prediction against the EX outcome; a non-branch is
    // treated as an actual not-taken.
    always_comb begin
        resolve      = (state_q == BR_IDLE) & bus.ex_valid_i & head_v & ~stall_i;
        actual_taken = bus.ex_is_jmp_i & (bus.ex_jmp_en_i == JMP_EN);
        pc_mismatch  = (head_pc != bus.ex_pc_i);
        mispredict   = resolve & (resolve_outcome(pc_mismatch, actual_taken,
                                                  head_jmp == JMP_EN,
                                                  bus.ex_target_i != head_tgt) == JMP_ERROR);
    end

    // Flush FSM: enter on mispredict, hold FLUSH for FLUSH_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (state_q == BR_IDLE) begin
            if (mispredict) begin
                state_d = BR_FLUSH;
                fcnt_d  = 3'(FLUSH_CYCLES);
            end
        end else begin
            if (fcnt_q == 3'd1) begin
                state_d = BR_IDLE;
            end else begin
                fcnt_d = fcnt_q - 3'd1;
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BR_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Registered redirect and BTB update, pulsed the cycle after EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_jmp_en_q  <= 1'b0;
            upd_target_q  <= '0;
        end else begin
            redirect_q  <= mispredict;
            upd_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual_taken ? bus.ex_target_i
                                              : bus.ex_pc_i + ADDR_W'(4);
                upd_pc_q      <= bus.ex_pc_i;
                upd_jmp_en_q  <= actual_taken;
                upd_target_q  <= actual_taken ? bus.ex_target_i
                                              : MEM_ADDR_ZERO[ADDR_W-1:0];
            end
        end
    end

    // Sticky desync flag and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve & pc_mismatch) begin
                sync_err_q <= 1'b1;
            end
            if (resolve & bus.ex_is_jmp_i & (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict & (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.upd_valid_o   = upd_valid_q;
    assign bus.upd_pc_o      = upd_pc_q;
    assign bus.upd_jmp_en_o  = upd_jmp_en_q;
    assign bus.upd_target_o  = upd_target_q;
    assign sync_err_o        = sync_err_q;
    assign branch_cnt_o      = branch_cnt_q;
    assign mispred_cnt_o     = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int AW           = 64;
    localparam int DEPTH        = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall_i = 1'b0;
    logic             flush_o;
    logic             sync_err_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    always #5 clk = ~clk;

    branch_resolve_if #(.ADDR_W(AW)) bus();

    branch_resolve #(.ADDR_W(AW), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES),
                     .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stall_i       (stall_i),
        .flush_o       (flush_o),
        .sync_err_o    (sync_err_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the in-flight predictions as a queue (newest first),
    // the remaining flush length and the expected output values.
    typedef struct {
        bit          v;
        logic [63:0] pc;
        bit          jmp;
        logic [63:0] tgt;
    } pred_t;

    pred_t       shadow[$];
    int          flush_left;
    bit          m_redir, m_uv, m_uj, m_sync;
    logic [63:0] m_rpc, m_upc, m_ut;
    int          m_bc, m_mc;

    task automatic model_reset();
        pred_t empty;
        empty = '{v: 1'b0, pc: 64'd0, jmp: 1'b0, tgt: 64'd0};
        shadow.delete();
        for (int i = 0; i < DEPTH; i++) shadow.push_back(empty);
        flush_left = 0;
        m_redir = 0; m_uv = 0; m_uj = 0; m_sync = 0;
        m_rpc = 0; m_upc = 0; m_ut = 0;
        m_bc = 0; m_mc = 0;
    endtask

    // One clock of the model, using the inputs that were stable at the edge.
    task automatic model_clock();
        pred_t head;
        pred_t fresh;
        bit    actual, wrong, flushing;
        head     = shadow[DEPTH-1];
        actual   = bus.ex_is_jmp_i && bus.ex_jmp_en_i;
        wrong    = 0;
        flushing = (flush_left != 0);
        m_redir  = 0;
        m_uv     = 0;
        if (!flushing && bus.ex_valid_i && head.v && !stall_i) begin
            wrong = (head.pc != bus.ex_pc_i) || (actual != head.jmp)
                  || (actual && bus.ex_target_i != head.tgt);
            if (bus.ex_is_jmp_i && m_bc < CNT_MAX) m_bc++;
            if (wrong) begin
                if (m_mc < CNT_MAX) m_mc++;
                if (head.pc != bus.ex_pc_i) m_sync = 1;
                m_redir = 1;
                m_uv    = 1;
                m_rpc   = actual ? bus.ex_target_i : bus.ex_pc_i + 64'd4;
                m_upc   = bus.ex_pc_i;
                m_uj    = actual;
                m_ut    = actual ? bus.ex_target_i : 64'd0;
            end
        end
        if (flushing) begin
            foreach (shadow[i]) shadow[i].v = 0;
        end else if (!stall_i) begin
            fresh = '{v: bus.if_valid_i, pc: bus.if_pc_i, jmp: bus.pred_jmp_i,
                      tgt: bus.pred_target_i};
            shadow.push_front(fresh);
            void'(shadow.pop_back());
        end
        if (flushing) flush_left--;
        else if (wrong) flush_left = FLUSH_CYCLES;
    endtask

    task automatic check_all();
        check("redirect",    64'(bus.redirect_o),    64'(m_redir));
        check("redirect_pc", bus.redirect_pc_o,      m_rpc);
        check("upd_valid",   64'(bus.upd_valid_o),   64'(m_uv));
        check("upd_pc",      bus.upd_pc_o,           m_upc);
        check("upd_jmp_en",  64'(bus.upd_jmp_en_o),  64'(m_uj));
        check("upd_target",  bus.upd_target_o,       m_ut);
        check("flush",       64'(flush_o),           64'(flush_left != 0));
        check("sync_err",    64'(sync_err_o),        64'(m_sync));
        check("branch_cnt",  64'(branch_cnt_o),      64'(m_bc));
        check("mispred_cnt", 64'(mispred_cnt_o),     64'(m_mc));
    endtask

    // Drive one cycle of inputs at the falling edge, clock the model at the
    // rising edge, then compare shortly after it.
    task automatic step(input bit ifv, input logic [63:0] ipc, input bit pj,
                        input logic [63:0] pt, input bit st, input bit exv,
                        input bit exj, input logic [63:0] epc, input bit een,
                        input logic [63:0] etg);
        @(negedge clk);
        bus.if_valid_i    = ifv;
        bus.if_pc_i       = ipc;
        bus.pred_jmp_i    = pj;
        bus.pred_target_i = pt;
        stall_i           = st;
        bus.ex_valid_i    = exv;
        bus.ex_is_jmp_i   = exj;
        bus.ex_pc_i       = epc;
        bus.ex_jmp_en_i   = een;
        bus.ex_target_i   = etg;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, JMP_DIS, 0, 0, 0, 0, 0, JMP_DIS, 0);
    endtask

    task automatic fetch(input logic [63:0] pc, input bit pj, input logic [63:0] pt);
        step(1, pc, pj, pt, 0, 0, 0, 0, JMP_DIS, 0);
    endtask

    task automatic exec(input bit exj, input logic [63:0] pc, input bit en, input logic [63:0] tgt);
        step(0, 0, JMP_DIS, 0, 0, 1, exj, pc, en, tgt);
    endtask

    initial begin
        logic [63:0] rpc, rtgt;
        bus.if_valid_i = 0; bus.if_pc_i = 0; bus.pred_jmp_i = 0; bus.pred_target_i = 0;
        bus.ex_valid_i = 0; bus.ex_is_jmp_i = 0; bus.ex_pc_i = 0;
        bus.ex_jmp_en_i = 0; bus.ex_target_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Correctly predicted taken branch.
        fetch(64'h40, JMP_EN, 64'h100);
        idle();
        exec(1, 64'h40, JMP_EN, 64'h100);
        check("t1_redirect", 64'(bus.redirect_o), 64'd0);
        check("t1_branch_cnt", 64'(branch_cnt_o), 64'd1);
        check("t1_mispred_cnt", 64'(mispred_cnt_o), 64'd0);

        // Predicted not-taken, actually taken.
        fetch(64'h80, JMP_DIS, 64'h0);
        idle();
        exec(1, 64'h80, JMP_EN, 64'h200);
        check("t2_redirect", 64'(bus.redirect_o), 64'd1);
        check("t2_redirect_pc", bus.redirect_pc_o, 64'h200);
        check("t2_upd_valid", 64'(bus.upd_valid_o), 64'd1);
        check("t2_upd_target", bus.upd_target_o, 64'h200);
        check("t2_flush1", 64'(flush_o), 64'd1);
        idle();
        check("t2_flush2", 64'(flush_o), 64'd1);
        check("t2_redirect_pulse", 64'(bus.redirect_o), 64'd0);
        idle();
        check("t2_flush_end", 64'(flush_o), 64'd0);

        // Predicted taken, actually not taken.
        fetch(64'h90, JMP_EN, 64'h300);
        idle();
        exec(1, 64'h90, JMP_DIS, 64'h0);
        check("t3_redirect_pc", bus.redirect_pc_o, 64'h94);
        check("t3_upd_jmp_en", 64'(bus.upd_jmp_en_o), 64'd0);
        check("t3_upd_target", bus.upd_target_o, 64'h0);
        idle();
        idle();

        // Target mismatch, then a would-be mispredict inside FLUSH.
        fetch(64'hA0, JMP_EN, 64'h100);
        fetch(64'hA4, JMP_DIS, 64'h0);
        exec(1, 64'hA0, JMP_EN, 64'h104);
        check("t4_redirect_pc", bus.redirect_pc_o, 64'h104);
        check("t4_mispred_cnt", 64'(mispred_cnt_o), 64'd3);
        exec(1, 64'hA4, JMP_EN, 64'h500);
        check("t4_in_flush_redirect", 64'(bus.redirect_o), 64'd0);
        exec(1, 64'hA4, JMP_EN, 64'h500);
        check("t4_last_flush_redirect", 64'(bus.redirect_o), 64'd0);
        check("t4_mispred_hold", 64'(mispred_cnt_o), 64'd3);

        // Stall holds the shadow entries; EX realigns after release.
        fetch(64'h40, JMP_EN, 64'h100);
        fetch(64'h48, JMP_DIS, 64'h0);
        repeat (3) step(1, 64'h4C, JMP_EN, 64'h999, 1, 1, 1, 64'h40, JMP_EN, 64'h100);
        check("t5_stall_no_count", 64'(branch_cnt_o), 64'd4);
        exec(1, 64'h40, JMP_EN, 64'h100);
        check("t5_redirect", 64'(bus.redirect_o), 64'd0);
        check("t5_branch_cnt", 64'(branch_cnt_o), 64'd5);
        exec(1, 64'h48, JMP_DIS, 64'h0);
        check("t5_sync_err", 64'(sync_err_o), 64'd0);
        check("t5_branch_cnt2", 64'(branch_cnt_o), 64'd6);

        // Reset in the middle of FLUSH, then a pc desync.
        fetch(64'h50, JMP_DIS, 64'h0);
        idle();
        exec(1, 64'h50, JMP_EN, 64'h600);
        check("t6_flush_before_rst", 64'(flush_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_flush", 64'(flush_o), 64'd0);
        check("t6_rst_redirect", 64'(bus.redirect_o), 64'd0);
        check("t6_rst_branch_cnt", 64'(branch_cnt_o), 64'd0);
        check("t6_rst_mispred_cnt", 64'(mispred_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(64'h40, JMP_DIS, 64'h0);
        idle();
        exec(0, 64'h44, JMP_DIS, 64'h0);
        check("t6_sync_err", 64'(sync_err_o), 64'd1);
        check("t6_redirect_pc", bus.redirect_pc_o, 64'h48);
        repeat (3) idle();
        check("t6_sync_sticky", 64'(sync_err_o), 64'd1);

        // Random traffic, EX mostly following the model's head prediction.
        for (int n = 0; n < 1500; n++) begin
            pred_t h;
            h   = shadow[DEPTH-1];
            rpc = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                               : {$urandom(), $urandom() & 32'hFFFF_FFFC};
            rtgt = {$urandom(), $urandom() & 32'hFFFF_FFFC};
            step($urandom_range(0, 3) != 0, rpc, 1'($urandom_range(0, 1)), rtgt,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 9) != 0) ? h.pc : rpc + 64'd8,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0) ? h.tgt : rtgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
